// File: rtl/rx_flag_destuff_if.sv
// Signal bundle between the serial HDLC line and the Rx controller.
// master drives the line and consumes results; slave is the receive front end.
interface rx_flag_destuff_if #(
  parameter int LEN_W = 8
);
  logic             rx;
  logic             flag_detect;
  logic             abort_detect;
  logic             idle;
  logic             valid_frame;
  logic             eof;
  logic             frame_error;
  logic [7:0]       data;
  logic             new_byte;
  logic [LEN_W-1:0] frame_len;

  modport master (
    output rx,
    input  flag_detect, abort_detect, idle, valid_frame, eof, frame_error,
           data, new_byte, frame_len
  );

  modport slave (
    input  rx,
    output flag_detect, abort_detect, idle, valid_frame, eof, frame_error,
           data, new_byte, frame_len
  );
endinterface

// File: rtl/rx_flag_destuff.sv
// HDLC receive front end: flag/abort/idle detection, zero destuffing, byte assembly, frame strobes.
// Optional idle detection is enabled by defining RX_IDLE_DETECT_EN.
module rx_flag_destuff #(
  parameter int LEN_W     = 8,
  parameter int FCS_BYTES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  rx_flag_destuff_if.slave bus
);
  localparam logic [7:0]       FLAG_PAT  = 8'h7E;
  localparam logic [7:0]       ABORT_PAT = 8'hFE;
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] FCS_LIM   = LEN_W'(FCS_BYTES);

  typedef enum logic [1:0] {HUNT, OPEN, ACTIVE, CLOSE} state_t;

  state_t           state;
  logic [7:0]       sr;
  logic [7:0]       vmask;
  logic [7:0]       shreg;
  logic [7:0]       data_q;
  logic [2:0]       ones;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic             flag_det;
  logic             abort_det;
  logic             idle_q;
  logic             new_byte_q;
  logic             odd_bits;
  logic             valid_q;
  logic             eof_q;
  logic             ferr_q;
  logic             close_abort;
  logic             flag_hit;
  logic             abort_hit;
  logic             take;

  assign flag_hit  = (sr == FLAG_PAT);
  assign abort_hit = (sr == ABORT_PAT);
  // The bit leaving sr[0] on a match edge is the first pattern bit, so the match itself masks it.
  assign take      = vmask[0] && (state == OPEN || state == ACTIVE);

  // Delay line, bit-valid mask and destuffing/byte assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= 8'h00;
      vmask      <= 8'h00;
      shreg      <= 8'h00;
      data_q     <= 8'h00;
      ones       <= 3'd0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      flag_det   <= 1'b0;
      abort_det  <= 1'b0;
      new_byte_q <= 1'b0;
      odd_bits   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here, so every branch sees the pre-edge sr/vmask/counters.
      sr         <= {bus.rx, sr[7:1]};
      flag_det   <= flag_hit;
      abort_det  <= abort_hit;
      new_byte_q <= 1'b0;
      if (flag_hit || abort_hit) begin
        vmask    <= 8'h80;
        ones     <= 3'd0;
        bit_cnt  <= 3'd0;
        odd_bits <= (bit_cnt != 3'd0);
      end else begin
        vmask <= {1'b1, vmask[7:1]};
        if (take) begin
          if (!sr[0] && ones == 3'd5) begin
            ones <= 3'd0;
          end else begin
            shreg   <= {sr[0], shreg[7:1]};
            ones    <= sr[0] ? ((ones == 3'd7) ? ones : ones + 3'd1) : 3'd0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_q     <= {sr[0], shreg[7:1]};
              new_byte_q <= 1'b1;
              // A byte completing in OPEN is the first of a new frame; the old length is held until then.
              byte_cnt   <= (state == OPEN) ? LEN_W'(1)
                          : ((byte_cnt == LEN_MAX) ? byte_cnt : byte_cnt + 1'b1);
            end
          end
        end
      end
    end
  end

`ifdef RX_IDLE_DETECT_EN
  localparam logic [7:0] IDLE_PAT = 8'hFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= 1'b0;
    else        idle_q <= (sr == IDLE_PAT);
  end
`else
  assign idle_q = 1'b0;
`endif

  // Frame FSM, reacting to the registered detect strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      close_abort <= 1'b0;
      valid_q     <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      eof_q  <= (state == CLOSE);
      ferr_q <= (state == CLOSE) && !close_abort && (odd_bits || byte_cnt <= FCS_LIM);
      case (state)
        HUNT: begin
          if (flag_det) state <= OPEN;
        end
        OPEN: begin
          if (flag_det) begin
            state <= OPEN;
          end else if (abort_det || idle_q) begin
            state <= HUNT;
          end else if (new_byte_q) begin
            state   <= ACTIVE;
            valid_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (flag_det || abort_det) begin
            state       <= CLOSE;
            close_abort <= !flag_det;
            valid_q     <= 1'b0;
          end
        end
        CLOSE: begin
          state <= close_abort ? HUNT : OPEN;
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.flag_detect  = flag_det;
  assign bus.abort_detect = abort_det;
  assign bus.idle         = idle_q;
  assign bus.valid_frame  = valid_q;
  assign bus.eof          = eof_q;
  assign bus.frame_error  = ferr_q;
  assign bus.data         = data_q;
  assign bus.new_byte     = new_byte_q;
  assign bus.frame_len    = byte_cnt;
endmodule
